b_tile_feeder: RTL
==================

// Module: b_tile_feeder
// PURPOSE
//  Upstream stage of the B-operand skew memory. Accepts a DIM x DIM int8 B tile as DIM packed row
//  beats over a valid/ready stream and buffers it. Then replays it into the skew memory: DIM load
//  cycles on Bin with en=1, then 3*DIM-2 drain cycles with en=1. Pulses tile_done when complete.
// PARAMETERS
//  BITS_AB  8   element width, two's complement
//  DIM      8   array dimension (rows per tile, elements per row); DIM >= 2
// PORTS
//  clk        in   1              clock, all logic rising-edge
//  rst_n      in   1              reset, synchronous, active-low
//  in_data    in   BITS_AB*DIM    packed row; column j = in_data[j*BITS_AB +: BITS_AB]
//  in_valid   in   1              in_data valid this cycle
//  in_ready   out  1              feeder accepts a beat this cycle
//  Bin        out  [DIM-1:0] signed BITS_AB   row presented to skew memory
//  en         out  1              enable to skew memory (load + drain)
//  busy       out  1              high in PUSH or DRAIN
//  tile_done  out  1              one-cycle pulse after the last drain cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=FILL, row_cnt=0, drain_cnt=0, en=0, tile_done=0,
//    all Bin lanes 0, buffer contents don't-care. Reset mid-PUSH/DRAIN aborts the tile; no tile_done.
//  - States: FILL -> PUSH -> DRAIN -> FILL.
//  - FILL: in_ready=1, en=0, busy=0. Beat accepted when in_valid&&in_ready; row row_cnt <= in_data,
//    row_cnt++. Gaps in in_valid hold row_cnt. On acceptance of row DIM-1: row_cnt<=0, next=PUSH.
//  - PUSH: in_ready=0, en=1, busy=1. Bin = buffer[row_cnt], row 0 first; row_cnt++ each cycle.
//    Exactly DIM cycles. Registered outputs: first PUSH cycle (Bin=row 0) is the cycle after the
//    accepting edge of row DIM-1. After row DIM-1 is presented: next=DRAIN, drain_cnt<=0.
//  - DRAIN: in_ready=0, en=1, busy=1, Bin=0. Exactly 3*DIM-2 cycles, counted by drain_cnt of width
//    $clog2(3*DIM-1). On the last one: next=FILL, tile_done=1 for the following cycle only.
//  - The cycle with tile_done=1 is already FILL with in_ready=1. A beat offered then is accepted as
//    row 0 of the next tile.
//  - in_valid while in_ready=0 has no effect. in_data is not sampled. Upstream holds the beat.
//  - en is never high in FILL. en is continuous: 4*DIM-2 cycles per tile, no bubbles.
//  - No arithmetic on data. Lanes pass bit-exact, sign preserved. Counters never wrap past bounds.
//  - Throughput: one tile per DIM (fill, if back-to-back) + 4*DIM-2 cycles. No overlap of FILL
//    with PUSH/DRAIN.
// STRUCTURE
//  - Shared package sa_pkg: typedef enum logic [1:0] {FILL, PUSH, DRAIN} feeder_state_t.
//    Also ROWBITS=$clog2(DIM) helper and DRAIN_CYCLES = 3*DIM-2 localparam function.
//  - One sub-module: tile_row_buf (DIM x DIM regs; write port row/data/we, async read port by row).
//  - Top: FSM, row_cnt, drain_cnt, output registers.
// TESTING
//  1. Reset check: hold rst_n=0 for 2 cycles -> en=0, busy=0, tile_done=0, in_ready=1, all Bin=0.
//  2. Load B[i][j]=i*DIM+j back-to-back (DIM=8). Expected:
//     - first PUSH cycle after beat 7 accepted, Bin=0..7;
//     - next cycles Bin=8..15 up to 56..63;
//     - 22 DRAIN cycles with en=1, Bin=0;
//     - then tile_done pulse, in_ready=1.
//  3. Gapped input: in_valid low on alternate cycles, B[i][j]=-(i+j) -> identical PUSH sequence
//     -> negative values sign-exact (e.g. Bin[7]=-14 on row 7).
//  4. Backpressure: in_valid=1 with distinct data throughout PUSH/DRAIN -> no beat consumed.
//     Next tile row 0 = beat offered in the tile_done cycle.
//  5. Reset during DRAIN cycle 5: rst_n=0 one cycle -> en=0 next cycle, no tile_done.
//     A fresh tile then loads from row 0 and replays correctly.
//  6. Integration with skew memory plus reference model: 10 random tiles back-to-back.
//     -> skew memory Bout matches model for all 3*DIM-2 drain cycles, 0 errors.

Source files
------------

// File: rtl/sa_pkg.sv
// Types and sizing helpers shared by the systolic-array operand feeders.
package sa_pkg;

  typedef enum logic [1:0] {
    FILL,
    PUSH,
    DRAIN
  } feeder_state_t;

  localparam int DEFAULT_BITS_AB = 8;
  localparam int DEFAULT_DIM     = 8;

  // A single-row tile still needs a 1-bit row index.
  function automatic int rowbits(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic int drain_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tile_row_buf.sv
// DIM-row tile buffer: one synchronous write port, one asynchronous read port, both by row.
module tile_row_buf
  import sa_pkg::*;
#(
  parameter  int BITS_AB = DEFAULT_BITS_AB,
  parameter  int DIM     = DEFAULT_DIM,
  localparam int ROWBITS = rowbits(DIM),
  localparam int ROW_W   = BITS_AB * DIM
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ROWBITS-1:0] wr_row,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic [ROWBITS-1:0] rd_row,
  output logic [ROW_W-1:0]   rd_data
);

  logic [ROW_W-1:0] mem [DIM];

  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/b_tile_feeder.sv
// Buffers one DIM x DIM B tile from a valid/ready stream, then replays it
// into the skew memory as DIM load cycles followed by 3*DIM-2 drain cycles.
module b_tile_feeder
  import sa_pkg::*;
#(
  parameter int BITS_AB = DEFAULT_BITS_AB,
  parameter int DIM     = DEFAULT_DIM
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BITS_AB*DIM-1:0]       in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DIM-1:0][BITS_AB-1:0]  Bin,
  output logic                         en,
  output logic                         busy,
  output logic                         tile_done
);

  localparam int ROWBITS      = rowbits(DIM);
  localparam int DRAIN_CYCLES = drain_cycles(DIM);
  localparam int DCW          = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ROWBITS-1:0] LAST_ROW   = ROWBITS'(DIM - 1);
  localparam logic [DCW-1:0]     LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

  feeder_state_t state, state_nxt;
  logic [ROWBITS-1:0]          row_cnt, row_nxt;
  logic [DCW-1:0]              drain_cnt, drain_nxt;
  logic [DIM-1:0][BITS_AB-1:0] bin_nxt;
  logic [BITS_AB*DIM-1:0]      rd_data;
  logic                        en_nxt, done_nxt, accept;

  assign in_ready = (state == FILL);
  assign busy     = (state != FILL);
  assign accept   = in_valid && in_ready;

  // Reading at row_nxt lets Bin be registered yet show row 0 in the first PUSH cycle.
  tile_row_buf #(
    .BITS_AB(BITS_AB),
    .DIM    (DIM)
  ) u_buf (
    .clk    (clk),
    .we     (accept),
    .wr_row (row_cnt),
    .wr_data(in_data),
    .rd_row (row_nxt),
    .rd_data(rd_data)
  );

  always_comb begin
    state_nxt = state;
    row_nxt   = row_cnt;
    drain_nxt = drain_cnt;
    done_nxt  = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (row_cnt == LAST_ROW) begin
            row_nxt   = '0;
            state_nxt = PUSH;
          end else begin
            row_nxt = row_cnt + ROWBITS'(1);
          end
        end
      end
      PUSH: begin
        if (row_cnt == LAST_ROW) begin
          row_nxt   = '0;
          drain_nxt = '0;
          state_nxt = DRAIN;
        end else begin
          row_nxt = row_cnt + ROWBITS'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) begin
          drain_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = FILL;
        end else begin
          drain_nxt = drain_cnt + DCW'(1);
        end
      end
      default: state_nxt = FILL;
    endcase
    en_nxt  = (state_nxt != FILL);
    bin_nxt = (state_nxt == PUSH) ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      row_cnt   <= '0;
      drain_cnt <= '0;
      en        <= 1'b0;
      tile_done <= 1'b0;
      Bin       <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_nxt;
      drain_cnt <= drain_nxt;
      en        <= en_nxt;
      tile_done <= done_nxt;
      Bin       <= bin_nxt;
    end
  end

endmodule
